spi_reg_burst: RTL and testbench

//  SPI-slave register bridge for the test harness. Successor of the single-shot SPI register port.

---
 rtl/spi_reg_burst.sv | 182 ++++++++++++++++++
 tb/tb_spi_reg_burst.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_burst.sv
// SPI-slave register bridge: 8-bit command, then REG_W-bit words with address auto-increment until CS rises.
// Pin events act ~3 clk after the pin edge (2-flop sync + edge detect); no backpressure, read data must beat the first data edge.
module spi_reg_burst #(
  parameter int ADDR_W   = 4,
  parameter int REG_W    = 32,
  parameter int CPOL     = 0,
  parameter int CPHA     = 0,
  parameter int AUTO_INC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              spi_clk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_addr_v,
  input  logic [REG_W-1:0]  reg_data_i,
  input  logic              reg_data_i_dv,
  output logic [REG_W-1:0]  reg_data_o,
  output logic              reg_data_o_dv,
  output logic              reg_rw,
  output logic [1:0]        txn_width,
  output logic              rd_underrun
);

  localparam int CNT_W = $clog2(REG_W + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CMD_LAST  = CNT_W'(7);
  localparam logic [CNT_W-1:0]  WORD_LAST = CNT_W'(REG_W - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(AUTO_INC);

  typedef enum logic [2:0] {IDLE, CMD, RD_REQ, RD_WAIT, TX, RX} state_t;

  state_t           state;
  logic [1:0]       sclk_sync, cs_sync, mosi_sync;
  logic             sclk_prev, cs_prev;
  logic             sclk_s, cs_n_s, mosi_s;
  logic             sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic             sample_edge, change_edge, first_edge, cs_fall, cs_rise;
  logic [CNT_W-1:0] bit_cnt;
  logic [7:0]       cmd_sr;
  logic             cmd_done;
  logic [REG_W-1:0] shift_buf;
  logic [REG_W-1:0] rx_word;
  logic             wr_stb, rd_stb, urun_stb;

  assign sclk_s = sclk_sync[1];
  assign cs_n_s = cs_sync[1];
  assign mosi_s = mosi_sync[1];

  // SPI clock edges only count inside a frame
  assign sclk_rise   = ~cs_n_s & sclk_s & ~sclk_prev;
  assign sclk_fall   = ~cs_n_s & ~sclk_s & sclk_prev;
  assign lead_edge   = (CPOL == 0) ? sclk_rise : sclk_fall;
  assign trail_edge  = (CPOL == 0) ? sclk_fall : sclk_rise;
  assign sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
  assign change_edge = (CPHA == 0) ? trail_edge : lead_edge;
  assign first_edge  = (CPHA == 0) ? sample_edge : change_edge;
  assign cs_fall     = cs_prev & ~cs_n_s;
  assign cs_rise     = ~cs_prev & cs_n_s;
  assign rx_word     = {shift_buf[REG_W-2:0], mosi_s};

  assign spi_miso      = (state == TX) & shift_buf[REG_W-1];
  assign reg_data_o_dv = wr_stb & ena;
  assign reg_addr_v    = rd_stb & ena;
  assign rd_underrun   = urun_stb & ena;

  // Synchronisers carry no reset so a reset mid-frame cannot fake a CS falling edge
  always_ff @(posedge clk) begin
    if (ena) begin
      sclk_sync <= {sclk_sync[0], spi_clk};
      cs_sync   <= {cs_sync[0], spi_cs_n};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      sclk_prev <= sclk_sync[1];
      cs_prev   <= cs_sync[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      cmd_sr     <= '0;
      cmd_done   <= 1'b0;
      shift_buf  <= '0;
      reg_data_o <= '0;
      reg_addr   <= '0;
      reg_rw     <= 1'b0;
      txn_width  <= 2'b11;
      wr_stb     <= 1'b0;
      rd_stb     <= 1'b0;
      urun_stb   <= 1'b0;
    end else if (ena) begin
      wr_stb   <= 1'b0;
      rd_stb   <= 1'b0;
      urun_stb <= 1'b0;
      // write strobe goes out with the word's own address, then steps
      if (wr_stb)
        reg_addr <= reg_addr + ADDR_STEP;

      if (cs_rise) begin
        state    <= IDLE;
        bit_cnt  <= '0;
        cmd_done <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              state    <= CMD;
              bit_cnt  <= '0;
              cmd_done <= 1'b0;
            end
          end
          CMD: begin
            if (cmd_done) begin
              cmd_done  <= 1'b0;
              reg_rw    <= cmd_sr[7];
              txn_width <= cmd_sr[6:5];
              reg_addr  <= cmd_sr[ADDR_W-1:0];
              bit_cnt   <= '0;
              state     <= cmd_sr[7] ? RX : RD_REQ;
            end else if (sample_edge) begin
              cmd_sr <= {cmd_sr[6:0], mosi_s};
              if (bit_cnt == CMD_LAST) begin
                bit_cnt  <= '0;
                cmd_done <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + CNT_ONE;
              end
            end
          end
          RX: begin
            if (sample_edge) begin
              shift_buf <= rx_word;
              if (bit_cnt == WORD_LAST) begin
                bit_cnt    <= '0;
                reg_data_o <= rx_word;
                wr_stb     <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + CNT_ONE;
              end
            end
          end
          RD_REQ: begin
            rd_stb <= 1'b1;
            state  <= RD_WAIT;
          end
          RD_WAIT: begin
            // For CPHA=0 the underrun edge is itself the word's first sample
            if (first_edge) begin
              urun_stb  <= 1'b1;
              shift_buf <= '0;
              bit_cnt   <= (CPHA == 0) ? CNT_ONE : '0;
              state     <= TX;
            end else if (reg_data_i_dv) begin
              shift_buf <= reg_data_i;
              bit_cnt   <= '0;
              state     <= TX;
            end
          end
          TX: begin
            if (change_edge && !((CPHA != 0) && (bit_cnt == '0)))
              shift_buf <= {shift_buf[REG_W-2:0], 1'b0};
            if (sample_edge) begin
              if (bit_cnt == WORD_LAST) begin
                bit_cnt  <= '0;
                reg_addr <= reg_addr + ADDR_STEP;
                state    <= RD_REQ;
              end else begin
                bit_cnt <= bit_cnt + CNT_ONE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_burst.sv
// Directed bench: three bridge instances (mode0, mode3, mode1) sharing SPI clock/data, one CS each.
module tb_spi_reg_burst;
  localparam int H = 10;

  logic clk = 1'b0;
  logic rst, ena, spi_clk, spi_mosi;
  logic [2:0] cs_n;
  logic [31:0] rd_data;
  logic rd_dv;
  logic miso [3];
  logic [3:0] addr [3];
  logic addr_v [3];
  logic [31:0] data_o [3];
  logic dv [3];
  logic rw [3];
  logic [1:0] tw [3];
  logic und [3];

  always #5 clk = ~clk;

  spi_reg_burst #(.ADDR_W(4), .REG_W(32), .CPOL(0), .CPHA(0), .AUTO_INC(1)) u_m0 (
    .clk(clk), .rst(rst), .ena(ena), .spi_clk(spi_clk), .spi_cs_n(cs_n[0]), .spi_mosi(spi_mosi),
    .spi_miso(miso[0]), .reg_addr(addr[0]), .reg_addr_v(addr_v[0]), .reg_data_i(rd_data),
    .reg_data_i_dv(rd_dv), .reg_data_o(data_o[0]), .reg_data_o_dv(dv[0]), .reg_rw(rw[0]),
    .txn_width(tw[0]), .rd_underrun(und[0]));

  spi_reg_burst #(.ADDR_W(4), .REG_W(32), .CPOL(1), .CPHA(1), .AUTO_INC(1)) u_m3 (
    .clk(clk), .rst(rst), .ena(ena), .spi_clk(spi_clk), .spi_cs_n(cs_n[1]), .spi_mosi(spi_mosi),
    .spi_miso(miso[1]), .reg_addr(addr[1]), .reg_addr_v(addr_v[1]), .reg_data_i(rd_data),
    .reg_data_i_dv(rd_dv), .reg_data_o(data_o[1]), .reg_data_o_dv(dv[1]), .reg_rw(rw[1]),
    .txn_width(tw[1]), .rd_underrun(und[1]));

  spi_reg_burst #(.ADDR_W(4), .REG_W(32), .CPOL(0), .CPHA(1), .AUTO_INC(1)) u_m1 (
    .clk(clk), .rst(rst), .ena(ena), .spi_clk(spi_clk), .spi_cs_n(cs_n[2]), .spi_mosi(spi_mosi),
    .spi_miso(miso[2]), .reg_addr(addr[2]), .reg_addr_v(addr_v[2]), .reg_data_i(rd_data),
    .reg_data_i_dv(rd_dv), .reg_data_o(data_o[2]), .reg_data_o_dv(dv[2]), .reg_rw(rw[2]),
    .txn_width(tw[2]), .rd_underrun(und[2]));

  int total = 0;
  int bad = 0;

  // strobe monitor, sampled on the falling clock edge
  int wr_cnt [3];
  int av_cnt [3];
  int und_cnt [3];
  logic [3:0]  wr_addr [3][8];
  logic [31:0] wr_data [3][8];
  logic [3:0]  av_addr [3][8];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (dv[i] === 1'b1) begin
        wr_addr[i][wr_cnt[i][2:0]] = addr[i];
        wr_data[i][wr_cnt[i][2:0]] = data_o[i];
        wr_cnt[i] = wr_cnt[i] + 1;
      end
      if (addr_v[i] === 1'b1) begin
        av_addr[i][av_cnt[i][2:0]] = addr[i];
        av_cnt[i] = av_cnt[i] + 1;
      end
      if (und[i] === 1'b1) und_cnt[i] = und_cnt[i] + 1;
    end
  end

  task automatic clr_mon();
    for (int i = 0; i < 3; i++) begin
      wr_cnt[i] = 0;
      av_cnt[i] = 0;
      und_cnt[i] = 0;
    end
  endtask

  // read-data responder for the mode1 instance: data two clocks after the request
  logic [31:0] rd_mem [16];
  bit resp_en = 1'b0;

  initial begin
    rd_dv = 1'b0;
    rd_data = '0;
    forever begin
      @(negedge clk);
      if (resp_en && addr_v[2] === 1'b1) begin
        @(negedge clk);
        @(negedge clk);
        rd_data = rd_mem[addr[2]];
        rd_dv = 1'b1;
        @(negedge clk);
        rd_dv = 1'b0;
      end
    end
  end

  // mid-frame hook: kind 1 = ena low for 20 clk, kind 2 = reset pulse
  int hook_bit = -1;
  int hook_kind = 0;
  int frz_dv, frz_wr;
  logic snap_miso, snap_rw, snap_av;
  logic [3:0] snap_addr;
  logic [1:0] snap_tw;
  logic [31:0] snap_do0;

  task automatic do_hook(input int which);
    if (hook_kind == 1) begin
      int pre;
      pre = wr_cnt[which];
      frz_dv = 0;
      ena = 1'b0;
      repeat (20) begin
        @(negedge clk);
        if (dv[which] !== 1'b0) frz_dv++;
      end
      frz_wr = wr_cnt[which] - pre;
      ena = 1'b1;
    end else if (hook_kind == 2) begin
      rst = 1'b1;
      @(negedge clk);
      snap_miso = miso[which];
      snap_addr = addr[which];
      snap_rw = rw[which];
      snap_tw = tw[which];
      snap_av = addr_v[which];
      snap_do0 = data_o[0];
      rst = 1'b0;
    end
  endtask

  // SPI master; tx/rx are left-aligned, bit i of the frame at [103-i]
  task automatic spi_frame(input int which, input bit cpol, input bit cpha, input int nbits,
                           input logic [103:0] tx, output logic [103:0] rx);
    rx = '0;
    spi_clk = cpol;
    spi_mosi = 1'b0;
    repeat (H) @(negedge clk);
    cs_n[which] = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        spi_mosi = tx[103-i];
        repeat (H) @(negedge clk);
        rx[103-i] = miso[which];
        spi_clk = ~cpol;
        if (i == hook_bit) do_hook(which);
        repeat (H) @(negedge clk);
        spi_clk = cpol;
      end else begin
        spi_clk = ~cpol;
        spi_mosi = tx[103-i];
        repeat (H) @(negedge clk);
        rx[103-i] = miso[which];
        spi_clk = cpol;
        if (i == hook_bit) do_hook(which);
        repeat (H) @(negedge clk);
      end
    end
    repeat (H) @(negedge clk);
    cs_n[which] = 1'b1;
    repeat (3 * H) @(negedge clk);
    hook_bit = -1;
    hook_kind = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (miso[0] !== 1'b0) begin bad++; $display("FAIL rst_miso: got %b want 0", miso[0]); end
    total++; if (addr[0] !== 4'h0) begin bad++; $display("FAIL rst_addr: got %h want 0", addr[0]); end
    total++; if (addr_v[0] !== 1'b0) begin bad++; $display("FAIL rst_addr_v: got %b want 0", addr_v[0]); end
    total++; if (dv[0] !== 1'b0) begin bad++; $display("FAIL rst_dv: got %b want 0", dv[0]); end
    total++; if (data_o[0] !== 32'h0) begin bad++; $display("FAIL rst_data_o: got %h want 0", data_o[0]); end
    total++; if (rw[0] !== 1'b0) begin bad++; $display("FAIL rst_rw: got %b want 0", rw[0]); end
    total++; if (tw[0] !== 2'b11) begin bad++; $display("FAIL rst_txn_width: got %b want 11", tw[0]); end
    total++; if (und[0] !== 1'b0) begin bad++; $display("FAIL rst_underrun: got %b want 0", und[0]); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write_single();
    logic [103:0] rx;
    clr_mon();
    spi_frame(0, 1'b0, 1'b0, 40, {8'h83, 32'hDEADBEEF, 64'h0}, rx);
    total++; if (wr_cnt[0] !== 1) begin bad++; $display("FAIL t1_wr_cnt: got %0d want 1", wr_cnt[0]); end
    total++; if (wr_addr[0][0] !== 4'h3) begin bad++; $display("FAIL t1_wr_addr: got %h want 3", wr_addr[0][0]); end
    total++; if (wr_data[0][0] !== 32'hDEADBEEF) begin bad++; $display("FAIL t1_wr_data: got %h want deadbeef", wr_data[0][0]); end
    total++; if (data_o[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL t1_data_held: got %h want deadbeef", data_o[0]); end
    total++; if (rw[0] !== 1'b1) begin bad++; $display("FAIL t1_rw: got %b want 1", rw[0]); end
    total++; if (tw[0] !== 2'b00) begin bad++; $display("FAIL t1_txn_width: got %b want 00", tw[0]); end
    total++; if (addr[0] !== 4'h4) begin bad++; $display("FAIL t1_addr_after: got %h want 4", addr[0]); end
    total++; if (rx !== 104'h0) begin bad++; $display("FAIL t1_miso_idle: got %h want 0", rx); end
  endtask

  task automatic test_write_burst();
    logic [103:0] rx;
    clr_mon();
    spi_frame(1, 1'b1, 1'b1, 104, {8'h8F, 32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF}, rx);
    total++; if (wr_cnt[1] !== 3) begin bad++; $display("FAIL t2_wr_cnt: got %0d want 3", wr_cnt[1]); end
    total++; if (wr_addr[1][0] !== 4'hF) begin bad++; $display("FAIL t2_addr0: got %h want f", wr_addr[1][0]); end
    total++; if (wr_addr[1][1] !== 4'h0) begin bad++; $display("FAIL t2_addr1: got %h want 0", wr_addr[1][1]); end
    total++; if (wr_addr[1][2] !== 4'h1) begin bad++; $display("FAIL t2_addr2: got %h want 1", wr_addr[1][2]); end
    total++; if (wr_data[1][0] !== 32'hCAFEF00D) begin bad++; $display("FAIL t2_data0: got %h want cafef00d", wr_data[1][0]); end
    total++; if (wr_data[1][1] !== 32'h01234567) begin bad++; $display("FAIL t2_data1: got %h want 01234567", wr_data[1][1]); end
    total++; if (wr_data[1][2] !== 32'h89ABCDEF) begin bad++; $display("FAIL t2_data2: got %h want 89abcdef", wr_data[1][2]); end
  endtask

  task automatic test_read_burst();
    logic [103:0] rx;
    clr_mon();
    resp_en = 1'b1;
    spi_frame(2, 1'b0, 1'b1, 72, {8'h02, 96'h0}, rx);
    resp_en = 1'b0;
    repeat (H) @(negedge clk);
    total++; if (rx[95:64] !== 32'h12345678) begin bad++; $display("FAIL t3_miso_w0: got %h want 12345678", rx[95:64]); end
    total++; if (rx[63:32] !== 32'hA5A50F0F) begin bad++; $display("FAIL t3_miso_w1: got %h want a5a50f0f", rx[63:32]); end
    total++; if (rx[103:96] !== 8'h00) begin bad++; $display("FAIL t3_miso_cmd: got %h want 00", rx[103:96]); end
    total++; if (av_cnt[2] !== 3) begin bad++; $display("FAIL t3_av_cnt: got %0d want 3", av_cnt[2]); end
    total++; if (av_addr[2][0] !== 4'h2) begin bad++; $display("FAIL t3_av_addr0: got %h want 2", av_addr[2][0]); end
    total++; if (av_addr[2][1] !== 4'h3) begin bad++; $display("FAIL t3_av_addr1: got %h want 3", av_addr[2][1]); end
    total++; if (und_cnt[2] !== 0) begin bad++; $display("FAIL t3_underrun: got %0d want 0", und_cnt[2]); end
    total++; if (rw[2] !== 1'b0) begin bad++; $display("FAIL t3_rw: got %b want 0", rw[2]); end
  endtask

  task automatic test_underrun();
    logic [103:0] rx;
    clr_mon();
    spi_frame(2, 1'b0, 1'b1, 40, {8'h04, 32'hFFFFFFFF, 64'h0}, rx);
    total++; if (und_cnt[2] !== 1) begin bad++; $display("FAIL t4_underrun_cnt: got %0d want 1", und_cnt[2]); end
    total++; if (rx[95:64] !== 32'h0) begin bad++; $display("FAIL t4_miso_zero: got %h want 0", rx[95:64]); end
    total++; if (av_addr[2][0] !== 4'h4) begin bad++; $display("FAIL t4_av_addr: got %h want 4", av_addr[2][0]); end
    total++; if (av_cnt[2] !== 2) begin bad++; $display("FAIL t4_av_cnt: got %0d want 2", av_cnt[2]); end
  endtask

  task automatic test_abort();
    logic [103:0] rx;
    clr_mon();
    spi_frame(0, 1'b0, 1'b0, 21, {8'h85, 13'h1FFF, 83'h0}, rx);
    total++; if (wr_cnt[0] !== 0) begin bad++; $display("FAIL t5_partial_dv: got %0d want 0", wr_cnt[0]); end
    total++; if (addr[0] !== 4'h5) begin bad++; $display("FAIL t5_addr_kept: got %h want 5", addr[0]); end
    spi_frame(0, 1'b0, 1'b0, 40, {8'h86, 32'h0BADF00D, 64'h0}, rx);
    total++; if (wr_cnt[0] !== 1) begin bad++; $display("FAIL t5_next_cnt: got %0d want 1", wr_cnt[0]); end
    total++; if (wr_addr[0][0] !== 4'h6) begin bad++; $display("FAIL t5_next_addr: got %h want 6", wr_addr[0][0]); end
    total++; if (wr_data[0][0] !== 32'h0BADF00D) begin bad++; $display("FAIL t5_next_data: got %h want 0badf00d", wr_data[0][0]); end
  endtask

  task automatic test_ena_freeze();
    logic [103:0] rx;
    clr_mon();
    frz_dv = -1;
    frz_wr = -1;
    hook_kind = 1;
    hook_bit = 39;
    spi_frame(0, 1'b0, 1'b0, 40, {8'h89, 32'h5A5AC3C3, 64'h0}, rx);
    total++; if (frz_dv !== 0) begin bad++; $display("FAIL t6_frozen_strobe: got %0d want 0", frz_dv); end
    total++; if (frz_wr !== 0) begin bad++; $display("FAIL t6_frozen_progress: got %0d want 0", frz_wr); end
    total++; if (wr_cnt[0] !== 1) begin bad++; $display("FAIL t6_resume_cnt: got %0d want 1", wr_cnt[0]); end
    total++; if (wr_addr[0][0] !== 4'h9) begin bad++; $display("FAIL t6_resume_addr: got %h want 9", wr_addr[0][0]); end
    total++; if (wr_data[0][0] !== 32'h5A5AC3C3) begin bad++; $display("FAIL t6_resume_data: got %h want 5a5ac3c3", wr_data[0][0]); end
  endtask

  task automatic test_reset_mid_tx();
    logic [103:0] rx;
    clr_mon();
    resp_en = 1'b1;
    hook_kind = 2;
    hook_bit = 20;
    spi_frame(2, 1'b0, 1'b1, 40, {8'h22, 96'h0}, rx);
    resp_en = 1'b0;
    total++; if (rx[95:88] !== 8'h12) begin bad++; $display("FAIL t7_pre_rst_bits: got %h want 12", rx[95:88]); end
    total++; if (snap_miso !== 1'b0) begin bad++; $display("FAIL t7_rst_miso: got %b want 0", snap_miso); end
    total++; if (snap_addr !== 4'h0) begin bad++; $display("FAIL t7_rst_addr: got %h want 0", snap_addr); end
    total++; if (snap_rw !== 1'b0) begin bad++; $display("FAIL t7_rst_rw: got %b want 0", snap_rw); end
    total++; if (snap_tw !== 2'b11) begin bad++; $display("FAIL t7_rst_txn_width: got %b want 11", snap_tw); end
    total++; if (snap_av !== 1'b0) begin bad++; $display("FAIL t7_rst_addr_v: got %b want 0", snap_av); end
    total++; if (snap_do0 !== 32'h0) begin bad++; $display("FAIL t7_rst_data_o: got %h want 0", snap_do0); end
    total++; if (rx[82:64] !== 19'h0) begin bad++; $display("FAIL t7_miso_after_rst: got %h want 0", rx[82:64]); end
    total++; if (av_cnt[2] !== 1) begin bad++; $display("FAIL t7_av_cnt: got %0d want 1", av_cnt[2]); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rd_mem[i] = 32'h0;
    rd_mem[2] = 32'h12345678;
    rd_mem[3] = 32'hA5A50F0F;
    rd_mem[4] = 32'h0F0F0F0F;
    ena = 1'b1;
    rst = 1'b1;
    cs_n = 3'b111;
    spi_clk = 1'b0;
    spi_mosi = 1'b0;
    clr_mon();
    repeat (5) @(negedge clk);
    test_reset();
    test_write_single();
    test_write_burst();
    test_read_burst();
    test_underrun();
    test_abort();
    test_ena_freeze();
    test_reset_mid_tx();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
